// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU address staging buffer: issue ops,
// source select values and the slot indices reserved by the core.
package lsu_pkg;

   // Operation applied to the issued address; 2'b11 behaves as pass
   typedef enum logic [1:0] {
      LSU_OP_PASS  = 2'b00,
      LSU_OP_INC   = 2'b01,
      LSU_OP_INCPG = 2'b10,
      LSU_OP_RSVD  = 2'b11
   } lsu_op_e;

   // Where the issued address comes from
   typedef enum logic {
      LSU_SRC_BUF = 1'b0,
      LSU_SRC_ALU = 1'b1
   } lsu_src_e;

   // Slots with a fixed meaning to the scheduler
   localparam int LSU_SLOT_VEC = 0;   // interrupt vector (t16)
   localparam int LSU_SLOT_RMW = 1;   // original address of a read-modify-write
   localparam int LSU_SLOT_PTR = 2;   // indirect pointer

endpackage

// File: rtl/lsu_adr_incr.sv
// Combinational address modifier: pass, full-width increment, or
// increment of the low byte only so the page (upper bits) never changes.
module lsu_adr_incr
   import lsu_pkg::*;
#(
   parameter int ADR_W = 16
) (
   input  logic [ADR_W-1:0] i_adr,
   input  logic [1:0]       i_op,
   output logic [ADR_W-1:0] o_adr
);

   logic [7:0] w_low_inc;

   // Page-local increment of the low byte; the carry out is simply dropped
   always_comb begin
      w_low_inc = i_adr[7:0] + 8'd1;
   end

   // Select the result for the requested op; unknown/reserved codes pass through
   always_comb begin
      o_adr = i_adr;
      case (i_op)
         LSU_OP_INC:   o_adr = i_adr + ADR_W'(1);
         LSU_OP_INCPG: o_adr = {i_adr[ADR_W-1:8], w_low_inc};
         default:      o_adr = i_adr;
      endcase
   end

endmodule

// File: rtl/lsu_adr_buffer.sv
// Address staging buffer between the ALU address path and the LSU.
// Keeps SLOTS saved addresses with valid bits and issues one registered,
// optionally incremented address per cycle, honouring the LSU stall.
// ADR_W must exceed 8 and SLOTS must be a power of two, at least 2.
module lsu_adr_buffer
   import lsu_pkg::*;
#(
   parameter int ADR_W  = 16,
   parameter int SLOTS  = 4,
   parameter int SLOT_W = $clog2(SLOTS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADR_W-1:0]  alu_adr,
   input  logic              sched_rd_en,
   input  logic              sched_rd_src,
   input  logic [SLOT_W-1:0] sched_rd_slot,
   input  logic [1:0]        sched_rd_op,
   input  logic              sched_wr,
   input  logic [SLOT_W-1:0] sched_wr_slot,
   input  logic              sched_clr,
   input  logic              lsu_stall,
   output logic [ADR_W-1:0]  lsu_adr,
   output logic              lsu_valid,
   output logic              lsu_err,
   output logic [SLOTS-1:0]  slot_valid
);

   logic [ADR_W-1:0] r_slot [SLOTS];
   logic [SLOTS-1:0] r_slot_valid;
   logic [ADR_W-1:0] r_lsu_adr;
   logic             r_lsu_valid;
   logic             r_lsu_err;

   logic             w_fwd;
   logic             w_issue;
   logic             w_err;
   logic [ADR_W-1:0] w_src;
   logic [ADR_W-1:0] w_op_adr;
   logic [SLOTS-1:0] w_slot_valid_nxt;

   // Pick the source address; a same-cycle write to the read slot is
   // forwarded so the reader sees the value being written (write-first)
   always_comb begin
      w_fwd   = sched_wr && (sched_rd_src == LSU_SRC_BUF) && (sched_wr_slot == sched_rd_slot);
      w_src   = r_slot[sched_rd_slot];
      if ((sched_rd_src == LSU_SRC_ALU) || w_fwd) begin
         w_src = alu_adr;
      end
      w_issue = sched_rd_en && !lsu_stall;
      w_err   = w_issue && (sched_rd_src == LSU_SRC_BUF) && !w_fwd && !r_slot_valid[sched_rd_slot];
   end

   lsu_adr_incr #(
      .ADR_W (ADR_W)
   ) u_incr (
      .i_adr (w_src),
      .i_op  (sched_rd_op),
      .o_adr (w_op_adr)
   );

   // Next slot-valid vector: clear first, then a write sets its bit so write wins
   always_comb begin
      w_slot_valid_nxt = r_slot_valid;
      if (sched_clr) begin
         w_slot_valid_nxt = '0;
      end
      if (sched_wr) begin
         w_slot_valid_nxt[sched_wr_slot] = 1'b1;
      end
   end

   // Slot storage has no reset; its contents only matter once the valid bit is set
   always_ff @(posedge clk) begin
      if (sched_wr) begin
         r_slot[sched_wr_slot] <= alu_adr;
      end
   end

   // Valid bits, cleared by reset, independent of the LSU stall
   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot_valid <= '0;
      end else begin
         r_slot_valid <= w_slot_valid_nxt;
      end
   end

   // Issue register: frozen while stalled, otherwise loads a new address or goes idle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lsu_adr   <= '0;
         r_lsu_valid <= 1'b0;
         r_lsu_err   <= 1'b0;
      end else begin
         r_lsu_err <= w_err;
         if (!lsu_stall) begin
            r_lsu_valid <= sched_rd_en;
            if (sched_rd_en) begin
               r_lsu_adr <= w_op_adr;
            end
         end
      end
   end

   assign lsu_adr    = r_lsu_adr;
   assign lsu_valid  = r_lsu_valid;
   assign lsu_err    = r_lsu_err;
   assign slot_valid = r_slot_valid;

endmodule

// File: tb/tb_lsu_adr_buffer.sv
// Directed self-checking bench for lsu_adr_buffer with default parameters.
module tb_lsu_adr_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] alu_adr;
   logic        sched_rd_en;
   logic        sched_rd_src;
   logic [1:0]  sched_rd_slot;
   logic [1:0]  sched_rd_op;
   logic        sched_wr;
   logic [1:0]  sched_wr_slot;
   logic        sched_clr;
   logic        lsu_stall;
   logic [15:0] lsu_adr;
   logic        lsu_valid;
   logic        lsu_err;
   logic [3:0]  slot_valid;

   int numCompared   = 0;
   int numMismatched = 0;

   lsu_adr_buffer #(
      .ADR_W (16),
      .SLOTS (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .alu_adr       (alu_adr),
      .sched_rd_en   (sched_rd_en),
      .sched_rd_src  (sched_rd_src),
      .sched_rd_slot (sched_rd_slot),
      .sched_rd_op   (sched_rd_op),
      .sched_wr      (sched_wr),
      .sched_wr_slot (sched_wr_slot),
      .sched_clr     (sched_clr),
      .lsu_stall     (lsu_stall),
      .lsu_adr       (lsu_adr),
      .lsu_valid     (lsu_valid),
      .lsu_err       (lsu_err),
      .slot_valid    (slot_valid)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Advance one clock edge; outputs are sampled 1 ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; alu_adr = '0; sched_rd_en = 0; sched_rd_src = 0; sched_rd_slot = 0;
      sched_rd_op = 0; sched_wr = 0; sched_wr_slot = 0; sched_clr = 0; lsu_stall = 0;
      step();
      rst = 1'b0;
      numCompared++; if (lsu_adr !== 16'h0000) begin numMismatched++; $display("[TB] FAIL reset_adr: got %h want 0000", lsu_adr); end
      numCompared++; if (lsu_valid !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_valid: got %b want 0", lsu_valid); end
      numCompared++; if (lsu_err !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_err: got %b want 0", lsu_err); end
      numCompared++; if (slot_valid !== 4'b0000) begin numMismatched++; $display("[TB] FAIL reset_slots: got %b want 0000", slot_valid); end
   endtask

   task automatic test_pass();
      sched_wr = 1; sched_wr_slot = 1; alu_adr = 16'h1234;
      step();
      sched_wr = 0; alu_adr = 16'hDEAD;
      numCompared++; if (slot_valid !== 4'b0010) begin numMismatched++; $display("[TB] FAIL write_valid: got %b want 0010", slot_valid); end
      sched_rd_en = 1; sched_rd_src = 0; sched_rd_slot = 1; sched_rd_op = 2'b00;
      step();
      sched_rd_en = 0;
      numCompared++; if (lsu_adr !== 16'h1234) begin numMismatched++; $display("[TB] FAIL pass_adr: got %h want 1234", lsu_adr); end
      numCompared++; if (lsu_valid !== 1'b1) begin numMismatched++; $display("[TB] FAIL pass_valid: got %b want 1", lsu_valid); end
      numCompared++; if (lsu_err !== 1'b0) begin numMismatched++; $display("[TB] FAIL pass_err: got %b want 0", lsu_err); end
      step();
      numCompared++; if (lsu_valid !== 1'b0) begin numMismatched++; $display("[TB] FAIL idle_valid: got %b want 0", lsu_valid); end
      numCompared++; if (lsu_adr !== 16'h1234) begin numMismatched++; $display("[TB] FAIL idle_hold: got %h want 1234", lsu_adr); end
   endtask

   task automatic test_incr();
      logic [1:0]  opTab  [5] = '{2'b10, 2'b01, 2'b01, 2'b11, 2'b10};
      logic [1:0]  slotTab[5] = '{2'd2, 2'd2, 2'd3, 2'd2, 2'd0};
      logic        srcTab [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [15:0] expTab [5] = '{16'h1200, 16'h1300, 16'h0000, 16'h12FF, 16'hAB00};
      sched_wr = 1; sched_wr_slot = 2; alu_adr = 16'h12FF;
      step();
      sched_wr_slot = 3; alu_adr = 16'hFFFF;
      step();
      sched_wr = 0; alu_adr = 16'hABFF;
      for (int i = 0; i < 5; i++) begin
         sched_rd_en = 1; sched_rd_src = srcTab[i]; sched_rd_slot = slotTab[i]; sched_rd_op = opTab[i];
         step();
         numCompared++; if (lsu_adr !== expTab[i]) begin numMismatched++; $display("[TB] FAIL incr_adr[%0d]: got %h want %h", i, lsu_adr, expTab[i]); end
         numCompared++; if (lsu_err !== 1'b0) begin numMismatched++; $display("[TB] FAIL incr_err[%0d]: got %b want 0", i, lsu_err); end
      end
      sched_rd_en = 0;
   endtask

   task automatic test_forward();
      sched_wr = 1; sched_wr_slot = 0; alu_adr = 16'hFFFE;
      sched_rd_en = 1; sched_rd_src = 0; sched_rd_slot = 0; sched_rd_op = 2'b01;
      step();
      sched_wr = 0;
      numCompared++; if (lsu_adr !== 16'hFFFF) begin numMismatched++; $display("[TB] FAIL fwd_adr: got %h want ffff", lsu_adr); end
      numCompared++; if (lsu_err !== 1'b0) begin numMismatched++; $display("[TB] FAIL fwd_err: got %b want 0", lsu_err); end
      numCompared++; if (slot_valid[0] !== 1'b1) begin numMismatched++; $display("[TB] FAIL fwd_slot0: got %b want 1", slot_valid[0]); end
   endtask

   task automatic test_stall();
      lsu_stall = 1;
      for (int i = 0; i < 3; i++) begin
         sched_rd_en = 1; sched_rd_src = (i == 0); sched_rd_slot = 2'(i + 1); sched_rd_op = 2'(i);
         alu_adr = 16'h1111 * 16'(i + 1);
         sched_wr = (i == 1); sched_wr_slot = 3;
         if (i == 1) alu_adr = 16'h5A5A;
         step();
         numCompared++; if (lsu_adr !== 16'hFFFF) begin numMismatched++; $display("[TB] FAIL stall_adr[%0d]: got %h want ffff", i, lsu_adr); end
         numCompared++; if (lsu_valid !== 1'b1) begin numMismatched++; $display("[TB] FAIL stall_valid[%0d]: got %b want 1", i, lsu_valid); end
      end
      sched_wr = 0; lsu_stall = 0;
      sched_rd_en = 1; sched_rd_src = 0; sched_rd_slot = 3; sched_rd_op = 2'b00;
      step();
      sched_rd_en = 0;
      numCompared++; if (lsu_adr !== 16'h5A5A) begin numMismatched++; $display("[TB] FAIL release_adr: got %h want 5a5a", lsu_adr); end
      numCompared++; if (lsu_valid !== 1'b1) begin numMismatched++; $display("[TB] FAIL release_valid: got %b want 1", lsu_valid); end
      numCompared++; if (slot_valid !== 4'b1111) begin numMismatched++; $display("[TB] FAIL release_slots: got %b want 1111", slot_valid); end
   endtask

   task automatic test_error();
      rst = 1;
      step();
      rst = 0;
      sched_rd_en = 1; sched_rd_src = 0; sched_rd_slot = 3; sched_rd_op = 2'b00;
      step();
      sched_rd_en = 0;
      numCompared++; if (lsu_err !== 1'b1) begin numMismatched++; $display("[TB] FAIL err_pulse: got %b want 1", lsu_err); end
      numCompared++; if (lsu_valid !== 1'b1) begin numMismatched++; $display("[TB] FAIL err_valid: got %b want 1", lsu_valid); end
      step();
      numCompared++; if (lsu_err !== 1'b0) begin numMismatched++; $display("[TB] FAIL err_once: got %b want 0", lsu_err); end
      sched_clr = 1; sched_wr = 1; sched_wr_slot = 1; alu_adr = 16'h7777;
      step();
      sched_clr = 0; sched_wr = 0;
      numCompared++; if (slot_valid !== 4'b0010) begin numMismatched++; $display("[TB] FAIL clr_wr: got %b want 0010", slot_valid); end
      sched_rd_en = 1; sched_rd_slot = 1;
      step();
      numCompared++; if (lsu_adr !== 16'h7777) begin numMismatched++; $display("[TB] FAIL clr_rd_adr: got %h want 7777", lsu_adr); end
      numCompared++; if (lsu_err !== 1'b0) begin numMismatched++; $display("[TB] FAIL clr_rd_err: got %b want 0", lsu_err); end
   endtask

   task automatic test_reset_stall();
      lsu_stall = 1; rst = 1;
      step();
      rst = 0; lsu_stall = 0; sched_rd_en = 0;
      numCompared++; if (lsu_adr !== 16'h0000) begin numMismatched++; $display("[TB] FAIL rst_stall_adr: got %h want 0000", lsu_adr); end
      numCompared++; if (lsu_valid !== 1'b0) begin numMismatched++; $display("[TB] FAIL rst_stall_valid: got %b want 0", lsu_valid); end
      numCompared++; if (lsu_err !== 1'b0) begin numMismatched++; $display("[TB] FAIL rst_stall_err: got %b want 0", lsu_err); end
      numCompared++; if (slot_valid !== 4'b0000) begin numMismatched++; $display("[TB] FAIL rst_stall_slots: got %b want 0000", slot_valid); end
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_pass();
      test_incr();
      test_forward();
      test_stall();
      test_error();
      test_reset_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
